// File: rtl/sm_conv_pkg.sv
// Shared definitions for the two's-complement to sign-magnitude converter.
//   - FSM state encodings (plain constants so older tools and logs decode them)
//   - cnt_width(): bit counter width for an N-bit word
package sm_conv_pkg;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StConv = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((64'd1 << w) < 64'(n)) begin
            w++;
        end
        return w;
    endfunction

    // The counter walks 0..N-2, so clog2(N-1) bits; keep at least one bit for N=2.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : clog2(n - 1);
    endfunction

endpackage

// File: rtl/serial_neg_cell.sv
// One-bit cell of the serial copy-to-first-one-then-invert negation.
// Ports:
//   b             current magnitude bit of the operand (LSB first)
//   sign          operand sign; when 0 the bit passes straight through
//   seen_one      a 1 has already been seen in a lower bit position
//   mag_bit       resulting magnitude bit
//   seen_one_next updated seen_one flag for the next bit
module serial_neg_cell
    import sm_conv_pkg::*;
(
    input  logic b,
    input  logic sign,
    input  logic seen_one,
    output logic mag_bit,
    output logic seen_one_next
);

    // Bits up to and including the lowest 1 are copied, everything above is inverted.
    assign mag_bit       = (sign && seen_one) ? ~b : b;
    assign seen_one_next = seen_one | b;

endmodule

// File: rtl/twos_to_signmag.sv
// Bit-serial N-bit two's-complement to sign-magnitude converter with
// valid/ready handshakes on both sides. One magnitude bit per clock.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_ready high only while idle
//   in_data             two's-complement operand
//   out_valid/out_ready output handshake; out_valid high only when done
//   out_sm              {sign, magnitude}
//   out_ovf             operand was -2^(N-1); out_sm saturated to all ones
module twos_to_signmag
    import sm_conv_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sm,
    output logic         out_ovf
);

    localparam int unsigned CntW = cnt_width(N);

    logic [1:0]      r_state;
    logic [N-1:0]    r_shreg;
    logic            r_sign;
    logic [CntW-1:0] r_cnt;
    logic            r_seen_one;
    logic [N-2:0]    r_mag;
    logic [N-1:0]    r_out_sm;
    logic            r_out_ovf;

    logic            w_mag_bit;
    logic            w_seen_one_next;
    logic [N-2:0]    w_mag_next;
    logic            w_last;

    // The shift register moves right each CONV cycle, so bit 0 is always
    // the original bit at position cnt.
    serial_neg_cell u_cell (
        .b             (r_shreg[0]),
        .sign          (r_sign),
        .seen_one      (r_seen_one),
        .mag_bit       (w_mag_bit),
        .seen_one_next (w_seen_one_next)
    );

    // Magnitude fills from the top; after N-1 shifts the first bit lands at bit 0.
    always_comb begin
        w_mag_next         = r_mag >> 1;
        w_mag_next[N-2]    = w_mag_bit;
    end

    assign w_last = (r_cnt == CntW'(N - 2));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_shreg    <= '0;
            r_sign     <= 1'b0;
            r_cnt      <= '0;
            r_seen_one <= 1'b0;
            r_mag      <= '0;
            r_out_sm   <= '0;
            r_out_ovf  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_shreg    <= in_data;
                        r_sign     <= in_data[N-1];
                        r_cnt      <= '0;
                        r_seen_one <= 1'b0;
                        r_mag      <= '0;
                        r_state    <= StConv;
                    end
                end
                StConv: begin
                    r_shreg    <= r_shreg >> 1;
                    r_mag      <= w_mag_next;
                    r_seen_one <= w_seen_one_next;
                    r_cnt      <= r_cnt + CntW'(1);
                    if (w_last) begin
                        r_state <= StDone;
                        // Negative with no 1 anywhere in the magnitude bits is -2^(N-1).
                        if (r_sign && !w_seen_one_next) begin
                            r_out_sm  <= '1;
                            r_out_ovf <= 1'b1;
                        end else begin
                            r_out_sm  <= {r_sign, w_mag_next};
                            r_out_ovf <= 1'b0;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        r_state   <= StIdle;
                        r_out_sm  <= '0;
                        r_out_ovf <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign out_sm    = r_out_sm;
    assign out_ovf   = r_out_ovf;

endmodule

// File: doc/twos_to_signmag.md
# twos_to_signmag

Sequential bit-serial converter from N-bit two's complement to N-bit sign-magnitude; the decode direction of the ALU's two's-complement negation path. It sits between the ALU result and any consumer that needs sign-magnitude, such as display/print logic or the sign-magnitude operand path. It uses a valid/ready handshake on both sides and processes one magnitude bit per clock with the copy-to-first-one-then-invert rule.

## Interface
- N, default 8, total word width (sign + N-1 magnitude bits); legal N ≥ 2
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word (high only in IDLE)
- in_data  input  N  two's-complement operand
- out_valid  output  1  out_sm/out_ovf valid (high only in DONE)
- out_ready  input  1  consumer accepts result
- out_sm  output  N  {sign, magnitude[N-2:0]}
- out_ovf  output  1  input was -2^(N-1), not representable

## Operation
- States: IDLE, CONV, DONE.
- IDLE: in_ready=1. When in_valid is high, latch in_data into the shift register, set sign ← in_data[N-1], cnt ← 0, seen_one ← 0, then go to CONV. in_data need not stay stable after acceptance.
- CONV: each cycle processes bit b = shreg[cnt], for cnt = 0..N-2:
  - sign=0: mag[cnt] ← b.
  - sign=1: mag[cnt] ← seen_one ? ~b : b; then seen_one ← seen_one | b.
  - cnt increments each cycle. Bit N-2 is processed on the cycle with cnt = N-2, and the FSM moves to DONE at the end of that cycle.
- DONE: out_valid=1. out_sm = {sign, mag}. out_sm and out_ovf are held stable until out_valid && out_ready, then the FSM returns to IDLE.
- Overflow: sign=1 and in_data[N-2:0] all zero → out_ovf=1 and out_sm = all ones (saturate to -(2^(N-1)-1)).
- Zero: input 0 → out_sm = 0, never "-0". A negative input other than the overflow case always has a nonzero magnitude.
- No input acceptance in CONV or DONE; in_valid is ignored there.

## Timing
- Reset (any state, including mid-CONV): state ← IDLE, in_ready=1 on the next cycle, out_valid=0, out_sm=0, out_ovf=0, cnt=0. Any in-flight word is discarded.
- Latency: input handshake at edge k → out_valid high starting the cycle after edge k+N-1 (N-1 CONV cycles).
- Throughput: at most one word per N+1 cycles with out_ready held high (1 IDLE + N-1 CONV + 1 DONE).
- All outputs are registered or decoded from the state register; there is no combinational path from in_* to out_* or from out_ready to in_ready.
- out_ready low in DONE: stall indefinitely with all outputs unchanged.
- rst and handshake on the same edge: rst wins.

## Structure
- Shared package `sm_conv_pkg`:
  - state encoding constants (IDLE=2'd0, CONV=2'd1, DONE=2'd2)
  - counter width function clog2(N-1)
- Sub-module `serial_neg_cell`: a combinational one-bit cell.
  - inputs: b, sign, seen_one
  - outputs: mag_bit, seen_one_next
  - Instantiated once inside the datapath. The FSM, counter and shift register stay in the top module.

## Test plan
All scenarios use N=8.
- Reset, then in_data=0x05 handshake → 7 cycles later out_sm=0x05, out_ovf=0, out_valid held until out_ready.
- in_data=0xFB (-5) → out_sm=0x85, out_ovf=0. in_data=0xFF (-1) → 0x81. in_data=0x81 (-127) → 0xFF, ovf=0.
- in_data=0x80 → out_sm=0xFF, out_ovf=1. in_data=0x00 → out_sm=0x00. in_data=0x7F → 0x7F.
- Backpressure: out_ready low for 10 cycles in DONE → outputs stable and in_ready=0 throughout; in_valid pulses during CONV/DONE are ignored; release → IDLE next cycle, then the next word converts correctly.
- Reset asserted on the 3rd CONV cycle of 0xFB → next cycle IDLE with all outputs 0; a following 0x03 converts to 0x03 with normal latency.
- Randomized back-to-back stream of 1000 words with random out_ready → compare against the reference model (sign, |x| saturated) and check exactly one output per accepted input.
